pu_vec_mac: RTL

//  - Next-generation conv2d processing unit: LANES-wide signed dot-product MAC with valid/ready handshake.
//  - Two modes, chosen per beat by select:
//    - psum pass-through (systolic chaining between neighbouring PUs);
//    - internal accumulation over a kernel window closed by in_last.
//  - Sits in the PE array between the weight/activation feeders and the psum collector.
//  - 2-stage pipeline: registered products, then adder tree + accumulate.

---
 rtl/pu_pkg.sv | 46 ++++
 rtl/pu_vec_mac_if.sv | 31 +++
 rtl/pu_adder_tree.sv | 43 ++++
 rtl/pu_vec_mac.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pu_pkg.sv
// Shared definitions for the conv2d processing-unit family.
// Contents: mode encodings for the per-beat select input, the product-width helper,
// and a width-generic saturating adder reused by PU variants built with PU_SATURATE_EN.
package pu_pkg;

   localparam logic MODE_PSUM = 1'b0;
   localparam logic MODE_ACC  = 1'b1;

   // Working width of sat_add; callers' operand widths must be below this.
   localparam int unsigned SAT_MAX_W = 64;

   typedef struct packed {
      logic                 sat;
      logic [SAT_MAX_W-1:0] sum;
   } sat_res_t;

   function automatic int unsigned prod_width(input int unsigned data_width);
      return 2 * data_width;
   endfunction

   // Adds two sign-extended width-bit values and clamps the result to the signed width-bit range.
   function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                        input logic signed [SAT_MAX_W-1:0] b,
                                        input int unsigned                 width);
      logic signed [SAT_MAX_W-1:0] one;
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      logic signed [SAT_MAX_W-1:0] total;
      sat_res_t                    res;
      one   = SAT_MAX_W'(1);
      hi    = (one <<< (width - 1)) - one;
      lo    = -hi - one;
      total = a + b;
      res.sat = 1'b0;
      res.sum = total;
      if (total > hi) begin
         res.sat = 1'b1;
         res.sum = hi;
      end else if (total < lo) begin
         res.sat = 1'b1;
         res.sum = lo;
      end
      return res;
   endfunction

endpackage

// File: rtl/pu_vec_mac_if.sv
// Beat/result bus of pu_vec_mac.
// Ports: in_valid/in_ready/select/in_last/w/x/psum (beat side),
//        out_valid/out_ready/data_out/sat (result side).
// master = feeder/collector side, slave = the PU.
interface pu_vec_mac_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LANES      = 4,
   parameter int unsigned ACC_WIDTH  = 40
);
   logic                        in_valid;
   logic                        in_ready;
   logic                        select;
   logic                        in_last;
   logic [LANES*DATA_WIDTH-1:0] w;
   logic [LANES*DATA_WIDTH-1:0] x;
   logic [ACC_WIDTH-1:0]        psum;
   logic                        out_valid;
   logic                        out_ready;
   logic [ACC_WIDTH-1:0]        data_out;
   logic                        sat;

   modport master (
      output in_valid, select, in_last, w, x, psum, out_ready,
      input  in_ready, out_valid, data_out, sat
   );

   modport slave (
      input  in_valid, select, in_last, w, x, psum, out_ready,
      output in_ready, out_valid, data_out, sat
   );
endinterface

// File: rtl/pu_adder_tree.sv
// Combinational pairwise reduction of LANES signed products into one OUT_WIDTH sum.
// Ports: prod (LANES x IN_WIDTH, each signed), sum (signed OUT_WIDTH).
// Each product is sign-extended before the first level; an odd element at any level
// passes straight through to the next level.
module pu_adder_tree #(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned LANES     = 4,
   parameter int unsigned OUT_WIDTH = 40
) (
   input  logic [LANES-1:0][IN_WIDTH-1:0] prod,
   output logic signed [OUT_WIDTH-1:0]    sum
);

   localparam int unsigned LEVELS = (LANES > 1) ? $clog2(LANES) : 0;

   // One spare column so the odd-element partner read stays in range.
   logic signed [OUT_WIDTH-1:0] node [LEVELS+1][LANES+1];

   always_comb begin
      int n;
      for (int l = 0; l <= LEVELS; l++) begin
         for (int i = 0; i <= LANES; i++) begin
            node[l][i] = '0;
         end
      end
      for (int i = 0; i < LANES; i++) begin
         node[0][i] = OUT_WIDTH'($signed(prod[i]));
      end
      n = LANES;
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = 0; i < (LANES + 1) / 2; i++) begin
            if (2 * i + 1 < n) begin
               node[l+1][i] = node[l][2*i] + node[l][2*i+1];
            end else if (2 * i < n) begin
               node[l+1][i] = node[l][2*i];
            end
         end
         n = (n + 1) / 2;
      end
      sum = node[LEVELS][0];
   end

endmodule

// File: rtl/pu_vec_mac.sv
// pu_vec_mac: LANES-wide signed dot-product MAC for the conv2d PE array.
// Ports: clk, rst (async, active-high), bus (pu_vec_mac_if.slave: beat in, result out).
// Per beat, select chooses psum pass-through (dot + psum emitted) or internal
// accumulation over a window closed by in_last. Two stages: registered products,
// then adder tree + add. A stalled output freezes both stages.
// Build option: define PU_SATURATE_EN for clamping adds and a live sat flag;
// otherwise adds wrap and sat is tied low.
module pu_vec_mac
   import pu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LANES      = 4,
   parameter int unsigned ACC_WIDTH  = 40
) (
   input logic        clk,
   input logic        rst,
   pu_vec_mac_if.slave bus
);

   localparam int unsigned PW = prod_width(DATA_WIDTH);

   logic                        stall;
   logic [LANES-1:0][PW-1:0]    prod_c;
   logic                        s1_valid;
   logic [LANES-1:0][PW-1:0]    s1_prod;
   logic                        s1_sel;
   logic                        s1_last;
   logic signed [ACC_WIDTH-1:0] s1_psum;
   logic signed [ACC_WIDTH-1:0] dot;
   logic signed [ACC_WIDTH-1:0] base_c;
   logic signed [ACC_WIDTH-1:0] sum_c;
   logic signed [ACC_WIDTH-1:0] acc;
   logic                        out_valid_q;
   logic [ACC_WIDTH-1:0]        data_q;

   assign stall         = out_valid_q & ~bus.out_ready;
   assign bus.in_ready  = ~stall;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_q;

   // Lane products at full 2*DATA_WIDTH precision.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod_c[i] = PW'($signed(bus.w[i*DATA_WIDTH +: DATA_WIDTH]))
                   * PW'($signed(bus.x[i*DATA_WIDTH +: DATA_WIDTH]));
      end
   end

   // S1: capture products and beat control on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_prod  <= '0;
         s1_sel   <= MODE_PSUM;
         s1_last  <= 1'b0;
         s1_psum  <= '0;
      end else if (!stall) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_prod <= prod_c;
            s1_sel  <= bus.select;
            s1_last <= bus.in_last;
            s1_psum <= bus.psum;
         end
      end
   end

   pu_adder_tree #(
      .IN_WIDTH  (PW),
      .LANES     (LANES),
      .OUT_WIDTH (ACC_WIDTH)
   ) u_tree (
      .prod (s1_prod),
      .sum  (dot)
   );

   // The other addend is the running accumulator in window mode, the incoming psum otherwise.
   assign base_c = (s1_sel == MODE_ACC) ? acc : s1_psum;

`ifdef PU_SATURATE_EN
   sat_res_t add_res_c;
   logic     add_sat_c;
   logic     sat_q;
   logic     acc_sat;

   always_comb begin
      add_res_c = sat_add(SAT_MAX_W'(base_c), SAT_MAX_W'(dot), ACC_WIDTH);
      sum_c     = add_res_c.sum[ACC_WIDTH-1:0];
      add_sat_c = add_res_c.sat;
   end

   // Sticky clamp flag across a window; published with the emitting result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_q   <= 1'b0;
         acc_sat <= 1'b0;
      end else if (!stall && s1_valid) begin
         if (s1_sel == MODE_PSUM) begin
            sat_q <= add_sat_c;
         end else if (s1_last) begin
            sat_q   <= acc_sat | add_sat_c;
            acc_sat <= 1'b0;
         end else begin
            acc_sat <= acc_sat | add_sat_c;
         end
      end
   end

   assign bus.sat = sat_q;
`else
   assign sum_c   = base_c + dot;
   assign bus.sat = 1'b0;
`endif

   // S2: emit psum results and closed windows, otherwise grow the accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         acc         <= '0;
      end else if (!stall) begin
         out_valid_q <= 1'b0;
         if (s1_valid) begin
            if (s1_sel == MODE_PSUM) begin
               data_q      <= sum_c;
               out_valid_q <= 1'b1;
            end else if (s1_last) begin
               data_q      <= sum_c;
               acc         <= '0;
               out_valid_q <= 1'b1;
            end else begin
               acc <= sum_c;
            end
         end
      end
   end

endmodule
